controlador_maquina_cafe: RTL and testbench

- Sequencing FSM for the coffee vending machine.
- Captures an inserted banknote code and waits for a single drink-button press.
- Drives the existing purchase-verifier datapath with registered operands and samples its mismatch flag (d_valor).
- Then runs a timed preparation, a timed error display, or a refund on selection timeout. Sits between the front-panel switches/buttons and the drink-dispense and display outputs.

---
 rtl/controlador_maquina_cafe.sv | 104 ++++++++++
 tb/tb_controlador_maquina_cafe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/controlador_maquina_cafe.sv
// Sequencing FSM for the coffee vending machine: banknote capture, single-button
// selection, verifier sampling, then timed preparation, timed error display, or refund.
module controlador_maquina_cafe #(
  parameter int T_PREPARO = 50,
  parameter int T_ERRO    = 10,
  parameter int T_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inserir,
  input  logic [2:0] chaves_cedulas,
  input  logic [3:0] bt,
  input  logic       d_valor,
  output logic [2:0] ver_cedulas,
  output logic [3:0] ver_bt,
  output logic [3:0] bebida,
  output logic       ocupado,
  output logic       erro,
  output logic       devolver,
  output logic [2:0] estado
);

  localparam int T_MAX_A = (T_PREPARO > T_ERRO) ? T_PREPARO : T_ERRO;
  localparam int T_MAX   = (T_MAX_A > T_TIMEOUT) ? T_MAX_A : T_TIMEOUT;
  localparam int CW      = $clog2(T_MAX) + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ESPERA   = 3'd1,
    VERIFICA = 3'd2,
    PREPARO  = 3'd3,
    ERRO     = 3'd4,
    DEVOLVE  = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] counter;
  logic [2:0]    cedula_reg;
  logic [3:0]    bt_reg;
  logic [3:0]    bt_prev;
  logic [3:0]    edge_bt;
  logic          sel_valid;

  // A selection is one fresh press while exactly one button is held.
  assign edge_bt   = bt & ~bt_prev;
  assign sel_valid = $onehot(edge_bt) && $onehot(bt);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (inserir && (chaves_cedulas != 3'b000)) state_n = ESPERA;
      ESPERA: begin
        if (sel_valid)                               state_n = VERIFICA;
        else if (counter == CW'(T_TIMEOUT - 1))      state_n = DEVOLVE;
      end
      VERIFICA: state_n = d_valor ? ERRO : PREPARO;
      PREPARO:  if (counter == CW'(T_PREPARO - 1)) state_n = IDLE;
      ERRO:     if (counter == CW'(T_ERRO - 1))    state_n = ESPERA;
      DEVOLVE:  state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with estado.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      cedula_reg <= 3'b000;
      bt_reg     <= 4'b0000;
      bt_prev    <= 4'b0000;
      bebida     <= 4'b0000;
      ocupado    <= 1'b0;
      erro       <= 1'b0;
      devolver   <= 1'b0;
    end else begin
      state   <= state_n;
      bt_prev <= bt;

      if ((state_n == state) && (state != IDLE)) counter <= counter + 1'b1;
      else                                       counter <= '0;

      if ((state == IDLE) && (state_n == ESPERA))
        cedula_reg <= chaves_cedulas;
      else if (((state == PREPARO) && (state_n == IDLE)) || (state == DEVOLVE))
        cedula_reg <= 3'b000;

      if ((state == ESPERA) && (state_n == VERIFICA))
        bt_reg <= bt;
      else if (((state == PREPARO) || (state == ERRO)) && (state_n != state))
        bt_reg <= 4'b0000;

      bebida   <= (state_n == PREPARO) ? bt_reg : 4'b0000;
      ocupado  <= (state_n != IDLE);
      erro     <= (state_n == ERRO);
      devolver <= (state_n == DEVOLVE);
    end
  end

  assign ver_cedulas = cedula_reg;
  assign ver_bt      = bt_reg;
  assign estado      = state;

endmodule

// File: tb/tb_controlador_maquina_cafe.sv
// Directed bench for controlador_maquina_cafe: purchase, rejection, refund,
// ignored inputs and mid-preparation reset, checked with immediate assertions.
module tb_controlador_maquina_cafe;

  logic       clk = 1'b0;
  logic       reset;
  logic       inserir;
  logic [2:0] chaves_cedulas;
  logic [3:0] bt;
  logic       d_valor;
  logic [2:0] ver_cedulas;
  logic [3:0] ver_bt;
  logic [3:0] bebida;
  logic       ocupado;
  logic       erro;
  logic       devolver;
  logic [2:0] estado;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  controlador_maquina_cafe dut (
    .clk            (clk),
    .reset          (reset),
    .inserir        (inserir),
    .chaves_cedulas (chaves_cedulas),
    .bt             (bt),
    .d_valor        (d_valor),
    .ver_cedulas    (ver_cedulas),
    .ver_bt         (ver_bt),
    .bebida         (bebida),
    .ocupado        (ocupado),
    .erro           (erro),
    .devolver       (devolver),
    .estado         (estado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Purchase verifier stand-in: valid only when the note pays for the pressed drink.
  always_comb begin
    case ({ver_cedulas, ver_bt})
      7'b001_1000: d_valor = 1'b0;
      7'b010_0010: d_valor = 1'b0;
      7'b011_0100: d_valor = 1'b0;
      7'b100_0001: d_valor = 1'b0;
      default:     d_valor = 1'b1;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed view {estado, bebida, ocupado, erro, devolver}
  function automatic logic [31:0] outs(input logic [2:0] e, input logic [3:0] b,
                                       input logic o, input logic r, input logic d);
    return {22'd0, e, b, o, r, d};
  endfunction

  function automatic logic [31:0] obs_outs();
    return {22'd0, estado, bebida, ocupado, erro, devolver};
  endfunction

  task automatic run_preparo(input string tag, input logic [3:0] drink);
    for (int i = 0; i < 50; i++) begin
      chk(tag, obs_outs(), outs(3'd3, drink, 1'b1, 1'b0, 1'b0));
      step();
    end
    chk({tag, "_done"}, obs_outs(), outs(3'd0, 4'b0000, 1'b0, 1'b0, 1'b0));
    chk({tag, "_credit"}, {25'd0, ver_cedulas, ver_bt}, 32'd0);
  endtask

  initial begin
    int t0;
    int pulses;
    int pulse_at;

    reset = 1'b1; inserir = 1'b0; chaves_cedulas = 3'b000; bt = 4'b0000;
    repeat (3) step();
    chk("reset_outs", obs_outs(), outs(3'd0, 4'b0000, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_quiet", {obs_outs()[9:0], ver_cedulas, ver_bt}, 32'd0);
    end

    // Expresso purchase, matching note.
    chaves_cedulas = 3'b001; inserir = 1'b1;
    step();
    chk("p1_espera", obs_outs(), outs(3'd1, 4'b0000, 1'b1, 1'b0, 1'b0));
    chk("p1_vercedulas", {29'd0, ver_cedulas}, 32'd1);
    inserir = 1'b0; chaves_cedulas = 3'b000;
    step(); step();
    bt = 4'b1000;
    step();
    chk("p1_verifica", obs_outs(), outs(3'd2, 4'b0000, 1'b1, 1'b0, 1'b0));
    chk("p1_verbt", {28'd0, ver_bt}, 32'h8);
    step();
    bt = 4'b0000;
    run_preparo("p1_preparo", 4'b1000);

    // Leite note with camomila button rejected, then leite accepted.
    chaves_cedulas = 3'b010; inserir = 1'b1;
    step();
    inserir = 1'b0; chaves_cedulas = 3'b000;
    bt = 4'b0100;
    step();
    chk("p2_verifica", obs_outs(), outs(3'd2, 4'b0000, 1'b1, 1'b0, 1'b0));
    step();
    for (int i = 0; i < 10; i++) begin
      chk("p2_erro", obs_outs(), outs(3'd4, 4'b0000, 1'b1, 1'b1, 1'b0));
      step();
    end
    chk("p2_back_espera", obs_outs(), outs(3'd1, 4'b0000, 1'b1, 1'b0, 1'b0));
    chk("p2_credit_kept", {25'd0, ver_cedulas, ver_bt}, {25'd0, 3'b010, 4'b0000});
    bt = 4'b0000;
    step();
    bt = 4'b0010;
    step();
    chk("p2_verifica2", {28'd0, ver_bt}, 32'h2);
    step();
    bt = 4'b0000;
    run_preparo("p2_preparo", 4'b0010);

    // Ignored inputs in IDLE.
    inserir = 1'b1; chaves_cedulas = 3'b000;
    step();
    chk("idle_zero_note", obs_outs(), outs(3'd0, 4'b0000, 1'b0, 1'b0, 1'b0));
    inserir = 1'b0; bt = 4'b1000;
    step();
    chk("idle_button", obs_outs(), outs(3'd0, 4'b0000, 1'b0, 1'b0, 1'b0));
    bt = 4'b0000;
    step();

    // Capuccino note, invalid presses only, then refund on timeout.
    chaves_cedulas = 3'b100; inserir = 1'b1;
    step();
    t0 = cyc;
    chk("p3_espera", obs_outs(), outs(3'd1, 4'b0000, 1'b1, 1'b0, 1'b0));
    chaves_cedulas = 3'b001;
    bt = 4'b0110;
    step();
    chk("p3_double_press", obs_outs(), outs(3'd1, 4'b0000, 1'b1, 1'b0, 1'b0));
    chk("p3_no_restack", {29'd0, ver_cedulas}, 32'd4);
    inserir = 1'b0; chaves_cedulas = 3'b000;
    bt = 4'b1100;
    step();
    bt = 4'b1000;
    step(); step();
    chk("p3_held_button", obs_outs(), outs(3'd1, 4'b0000, 1'b1, 1'b0, 1'b0));
    chk("p3_held_verbt", {28'd0, ver_bt}, 32'd0);
    bt = 4'b0000;
    pulses = 0; pulse_at = -1;
    for (int i = 0; i < 300; i++) begin
      if (devolver) begin
        pulses++;
        pulse_at = cyc - t0;
      end
      step();
    end
    chk("p3_refund_count", pulses, 32'd1);
    chk("p3_refund_time", pulse_at, 32'd200);
    chk("p3_after_refund", {obs_outs()[9:0], ver_cedulas, ver_bt}, 32'd0);

    // Reset during preparation, then a clean purchase.
    chaves_cedulas = 3'b011; inserir = 1'b1;
    step();
    inserir = 1'b0; chaves_cedulas = 3'b000;
    bt = 4'b0100;
    step(); step();
    chk("p4_preparo", obs_outs(), outs(3'd3, 4'b0100, 1'b1, 1'b0, 1'b0));
    repeat (19) step();
    chk("p4_preparo_c20", obs_outs(), outs(3'd3, 4'b0100, 1'b1, 1'b0, 1'b0));
    reset = 1'b1; bt = 4'b0000;
    step();
    chk("p4_reset_abort", {obs_outs()[9:0], ver_cedulas, ver_bt}, 32'd0);
    reset = 1'b0;
    step();
    chk("p4_reset_idle", obs_outs(), outs(3'd0, 4'b0000, 1'b0, 1'b0, 1'b0));
    chaves_cedulas = 3'b100; inserir = 1'b1;
    step();
    inserir = 1'b0; chaves_cedulas = 3'b000;
    bt = 4'b0001;
    step();
    chk("p5_verifica", {25'd0, ver_cedulas, ver_bt}, {25'd0, 3'b100, 4'b0001});
    step();
    bt = 4'b0000;
    run_preparo("p5_preparo", 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
